pc_fetch_sequencer: RTL

- Upstream neighbour of the pipelined CPU top. Owns the program counter and drives the CPU's instruction address input.
- Consumes the CPU's PC+4 output (Next_Addr) and its PC_Write stall signal.
- Sequences a program run: IDLE -> RUN -> DRAIN -> DONE. DRAIN feeds NOPs so the last real instruction retires.
- Keeps saturating performance counters for cycles, stalls and fetches.

---
 rtl/pc_fetch_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the program counter in front of the pipelined CPU.
// Runs one program pass IDLE -> RUN -> DRAIN -> DONE. During DRAIN it presents
// NOP_ADDR so the instructions already in the pipe can retire. It also keeps
// saturating cycle, stall and fetch counters.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] END_PC       = 32'h0000_00FC,
   parameter logic [31:0] NOP_ADDR     = 32'h0000_0FFC,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt_req,
   input  logic        PC_Write,
   input  logic [31:0] Next_Addr,
   output logic [31:0] Input_Addr,
   output logic        run,
   output logic        done,
   output logic [31:0] cycle_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0]  DRAIN_INIT  = 4'(DRAIN_CYCLES);
   localparam logic [31:0] RESET_ALIGN = {RESET_PC[31:2], 2'b00};

   state_t      r_state;
   logic [31:0] r_pc;
   logic [3:0]  r_drain_cnt;
   logic        r_run;
   logic        r_done;
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fetch_cnt;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [3:0]  w_drain_nxt;
   logic [31:0] w_cycle_nxt;
   logic [31:0] w_stall_nxt;
   logic [31:0] w_fetch_nxt;
   logic        w_run_nxt;
   logic        w_done_nxt;
   logic        w_end_fetch;

   // The CPU always produces a word address. Its two low bits are never used.
   logic        w_unused_lo;
   assign w_unused_lo = ^Next_Addr[1:0];

   // Counters stop at all-ones. They do not wrap to zero.
   function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // The last program word is fetched only when the CPU actually accepts it.
   assign w_end_fetch = PC_Write && (r_pc == END_PC);

   // Outside RUN, point the CPU at the NOP hole so the pipe fills with bubbles.
   assign Input_Addr = (r_state == S_RUN) ? r_pc : NOP_ADDR;
   assign run        = r_run;
   assign done       = r_done;
   assign cycle_cnt  = r_cycle_cnt;
   assign stall_cnt  = r_stall_cnt;
   assign fetch_cnt  = r_fetch_cnt;

   // Next-state, program-counter and counter update logic.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_drain_nxt = r_drain_cnt;
      w_cycle_nxt = r_cycle_cnt;
      w_stall_nxt = r_stall_cnt;
      w_fetch_nxt = r_fetch_cnt;

      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = RESET_ALIGN;
               w_cycle_nxt = '0;
               w_stall_nxt = '0;
               w_fetch_nxt = '0;
            end
         end
         S_RUN: begin
            w_cycle_nxt = f_sat_inc(r_cycle_cnt);
            if (PC_Write) begin
               w_pc_nxt    = {Next_Addr[31:2], 2'b00};
               w_fetch_nxt = f_sat_inc(r_fetch_cnt);
            end else begin
               w_stall_nxt = f_sat_inc(r_stall_cnt);
            end
            // On a halt with PC_Write=1 the CPU has already latched the word
            // at r_pc, so the fetch counted above is kept.
            if (w_end_fetch || halt_req) begin
               w_state_nxt = S_DRAIN;
               w_drain_nxt = DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            w_cycle_nxt = f_sat_inc(r_cycle_cnt);
            // Stalled cycles do not advance the pipe, so they do not count
            // toward the drain.
            if (PC_Write) begin
               w_drain_nxt = r_drain_cnt - 4'd1;
               if (r_drain_cnt == 4'd1) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_run_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      w_done_nxt = (w_state_nxt == S_DONE);
   end

   // State register with synchronous reset. Reset overrides start and halt.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before this clock edge.
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_ALIGN;
         r_drain_cnt <= '0;
         r_run       <= 1'b0;
         r_done      <= 1'b0;
         r_cycle_cnt <= '0;
         r_stall_cnt <= '0;
         r_fetch_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_drain_cnt <= w_drain_nxt;
         r_run       <= w_run_nxt;
         r_done      <= w_done_nxt;
         r_cycle_cnt <= w_cycle_nxt;
         r_stall_cnt <= w_stall_nxt;
         r_fetch_cnt <= w_fetch_nxt;
      end
   end

endmodule
